// File: rtl/reg_bank_atomic_pkg.sv
// Shared address offsets and CTRL bit positions for the atomic register bank.
// Offsets are relative to pBASE_ADDR + pNUM_REGS (just past the data registers).
package reg_bank_atomic_pkg;

    localparam int STATUS_OFS  = 0;
    localparam int CTRL_OFS    = 1;
    localparam int PENDING_OFS = 2;

    localparam int CTRL_COMMIT_ALL_BIT  = 0;
    localparam int CTRL_AUTO_COMMIT_BIT = 1;

endpackage

// File: rtl/reg_bank_sticky.sv
// Sticky status vector: bits set on event inputs, cleared by host write-1-to-clear.
// A set arriving in the same cycle as its clear wins, so no event is ever lost.
module reg_bank_sticky #(
    parameter int pSTICKY_BITS = 8
) (
    input  logic                    clk_usb,
    input  logic                    reset_i,
    input  logic [pSTICKY_BITS-1:0] set_i,
    input  logic [pSTICKY_BITS-1:0] clr_i,
    output logic [pSTICKY_BITS-1:0] sticky_o
);

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            sticky_o <= '0;
        end else begin
            sticky_o <= (sticky_o & ~clr_i) | set_i;
        end
    end

endmodule

// File: rtl/reg_bank_atomic.sv
// Host register bank with per-register shadow staging and atomic commit, so that
// capture logic never observes a half-written multi-byte setting.
module reg_bank_atomic
    import reg_bank_atomic_pkg::*;
#(
    parameter int           pBYTECNT_SIZE = 7,
    parameter int           pNUM_REGS     = 8,
    parameter int           pREG_BYTES    = 4,
    parameter logic [7:0]   pBASE_ADDR    = 8'h60,
    parameter int           pSTICKY_BITS  = 8
) (
    input  logic                              clk_usb,
    input  logic                              reset_i,
    input  logic [7:0]                        reg_address,
    input  logic [pBYTECNT_SIZE-1:0]          reg_bytecnt,
    input  logic [7:0]                        reg_datai,
    output logic [7:0]                        reg_datao,
    input  logic                              reg_read,
    input  logic                              reg_write,
    output logic [pNUM_REGS*pREG_BYTES*8-1:0] regs_o,
    output logic [pNUM_REGS-1:0]              load_o,
    input  logic [pSTICKY_BITS-1:0]           sticky_set_i,
    output logic [pSTICKY_BITS-1:0]           sticky_o
);

    logic [7:0]                              rel_addr;
    logic                                    status_hit;
    logic                                    ctrl_hit;
    logic                                    pending_hit;
    logic                                    auto_commit_q;
    logic                                    commit_all;
    logic [pSTICKY_BITS-1:0]                 sticky_clr;
    logic [pNUM_REGS-1:0]                    pending_w;
    logic [pNUM_REGS-1:0][pREG_BYTES-1:0][7:0] committed_w;

    // Addresses below the base wrap to large offsets and fall outside the map.
    assign rel_addr    = reg_address - pBASE_ADDR;
    assign status_hit  = (rel_addr == 8'(pNUM_REGS + STATUS_OFS));
    assign ctrl_hit    = (rel_addr == 8'(pNUM_REGS + CTRL_OFS));
    assign pending_hit = (rel_addr == 8'(pNUM_REGS + PENDING_OFS));

    assign commit_all = reg_write && ctrl_hit && reg_datai[CTRL_COMMIT_ALL_BIT];
    assign sticky_clr = (reg_write && status_hit) ? reg_datai[pSTICKY_BITS-1:0] : '0;

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            auto_commit_q <= 1'b1;
        end else if (reg_write && ctrl_hit) begin
            auto_commit_q <= reg_datai[CTRL_AUTO_COMMIT_BIT];
        end
    end

    for (genvar gi = 0; gi < pNUM_REGS; gi++) begin : g_reg
        logic [pREG_BYTES-1:0][7:0] shadow_q;
        logic [pREG_BYTES-1:0][7:0] shadow_nxt;
        logic [pREG_BYTES-1:0][7:0] committed_q;
        logic                       pending_q;
        logic                       load_q;
        logic                       reg_hit;
        logic                       byte_wr;
        logic                       last_byte;
        logic                       commit;

        assign reg_hit = reg_write && (rel_addr == 8'(gi));

        always_comb begin
            shadow_nxt = shadow_q;
            byte_wr    = 1'b0;
            last_byte  = 1'b0;
            for (int b = 0; b < pREG_BYTES; b++) begin
                if (reg_hit && (reg_bytecnt == pBYTECNT_SIZE'(b))) begin
                    shadow_nxt[b] = reg_datai;
                    byte_wr       = 1'b1;
                    last_byte     = (b == pREG_BYTES - 1);
                end
            end
        end

        // The committing byte is folded in via shadow_nxt, so it lands in the same edge.
        assign commit = (last_byte && auto_commit_q) || (commit_all && pending_q);

        always_ff @(posedge clk_usb) begin
            if (reset_i) begin
                shadow_q    <= '0;
                committed_q <= '0;
                pending_q   <= 1'b0;
                load_q      <= 1'b0;
            end else begin
                shadow_q <= shadow_nxt;
                load_q   <= commit;
                if (commit) begin
                    committed_q <= shadow_nxt;
                    pending_q   <= 1'b0;
                end else if (byte_wr) begin
                    pending_q   <= 1'b1;
                end
            end
        end

        assign committed_w[gi] = committed_q;
        assign pending_w[gi]   = pending_q;
        assign load_o[gi]      = load_q;
    end

    assign regs_o = committed_w;

    reg_bank_sticky #(
        .pSTICKY_BITS(pSTICKY_BITS)
    ) u_sticky (
        .clk_usb  (clk_usb),
        .reset_i  (reset_i),
        .set_i    (sticky_set_i),
        .clr_i    (sticky_clr),
        .sticky_o (sticky_o)
    );

    // Reads return committed data, never the staged shadow.
    always_comb begin
        reg_datao = '0;
        if (reg_read) begin
            for (int i = 0; i < pNUM_REGS; i++) begin
                for (int b = 0; b < pREG_BYTES; b++) begin
                    if ((rel_addr == 8'(i)) && (reg_bytecnt == pBYTECNT_SIZE'(b))) begin
                        reg_datao = committed_w[i][b];
                    end
                end
            end
            if (status_hit) begin
                reg_datao = 8'(sticky_o);
            end
            if (ctrl_hit) begin
                reg_datao[CTRL_AUTO_COMMIT_BIT] = auto_commit_q;
            end
            if (pending_hit) begin
                reg_datao = 8'(pending_w);
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_atomic.sv
// Self-checking bench for reg_bank_atomic: scoreboard of expected commit results
// pushed as each write is driven and compared once the clock edge has taken it.
module tb_reg_bank_atomic;

    localparam int         NR   = 8;
    localparam int         RB   = 4;
    localparam int         RW   = RB * 8;
    localparam logic [7:0] BASE = 8'h60;
    localparam logic [7:0] A_STATUS = BASE + 8'd8;
    localparam logic [7:0] A_CTRL   = BASE + 8'd9;
    localparam logic [7:0] A_PEND   = BASE + 8'd10;

    logic            clk_usb = 1'b0;
    logic            reset_i;
    logic [7:0]      reg_address;
    logic [6:0]      reg_bytecnt;
    logic [7:0]      reg_datai;
    logic [7:0]      reg_datao;
    logic            reg_read;
    logic            reg_write;
    logic [NR*RW-1:0] regs_o;
    logic [NR-1:0]   load_o;
    logic [7:0]      sticky_set_i;
    logic [7:0]      sticky_o;

    typedef struct {
        string       nm;
        int          ridx;
        logic [31:0] regv;
        logic [7:0]  load;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk_usb = ~clk_usb;

    reg_bank_atomic #(
        .pBYTECNT_SIZE(7),
        .pNUM_REGS    (NR),
        .pREG_BYTES   (RB),
        .pBASE_ADDR   (BASE),
        .pSTICKY_BITS (8)
    ) dut (
        .clk_usb      (clk_usb),
        .reset_i      (reset_i),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .reg_datai    (reg_datai),
        .reg_datao    (reg_datao),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .regs_o       (regs_o),
        .load_o       (load_o),
        .sticky_set_i (sticky_set_i),
        .sticky_o     (sticky_o)
    );

    function automatic logic [31:0] reg_val(input int i);
        return regs_o[i*RW +: RW];
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
        @(negedge clk_usb);
        reg_address = a;
        reg_bytecnt = bc;
        reg_datai   = d;
        reg_write   = 1'b1;
        @(posedge clk_usb);
        #1;
        reg_write   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [6:0] bc, output logic [7:0] d);
        @(negedge clk_usb);
        reg_address = a;
        reg_bytecnt = bc;
        reg_read    = 1'b1;
        #1;
        d        = reg_datao;
        reg_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] want;
        logic [7:0] addrs[13];
        reset_i = 1'b1;
        repeat (3) begin
            @(posedge clk_usb);
            #1;
            vectors++;
            if (load_o !== '0) begin
                $display("FAIL reset_load: got %h want 00", load_o);
                miscompares++;
            end
        end
        reset_i = 1'b0;
        vectors++;
        if (regs_o !== '0) begin
            $display("FAIL reset_regs: got %h want 0", regs_o);
            miscompares++;
        end
        vectors++;
        if (sticky_o !== 8'h00) begin
            $display("FAIL reset_sticky: got %h want 00", sticky_o);
            miscompares++;
        end
        for (int i = 0; i < 11; i++) addrs[i] = BASE + 8'(i);
        addrs[11] = BASE + 8'd11;
        addrs[12] = 8'h10;
        for (int i = 0; i < 13; i++) begin
            bus_read(addrs[i], 7'd0, d);
            want = (addrs[i] == A_CTRL) ? 8'h02 : 8'h00;
            vectors++;
            if (d !== want) begin
                $display("FAIL reset_read_%h: got %h want %h", addrs[i], d, want);
                miscompares++;
            end
            vectors++;
            if (load_o !== '0) begin
                $display("FAIL reset_idle_load: got %h want 00", load_o);
                miscompares++;
            end
        end
    endtask

    task automatic test_auto_commit();
        exp_t       e;
        logic [7:0] d;
        logic [7:0] bytes[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [31:0] regv[4]  = '{32'h0, 32'h0, 32'h0, 32'h44332211};
        logic [7:0] loads[4]  = '{8'h00, 8'h00, 8'h00, 8'h04};
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{$sformatf("auto_b%0d", k), 2, regv[k], loads[k]});
            bus_write(BASE + 8'd2, 7'(k), bytes[k]);
            e = sb.pop_front();
            vectors++;
            if (reg_val(e.ridx) !== e.regv) begin
                $display("FAIL %s_regs: got %h want %h", e.nm, reg_val(e.ridx), e.regv);
                miscompares++;
            end
            vectors++;
            if (load_o !== e.load) begin
                $display("FAIL %s_load: got %h want %h", e.nm, load_o, e.load);
                miscompares++;
            end
            if (k < 3) begin
                bus_read(A_PEND, 7'd0, d);
                vectors++;
                if (d !== 8'h04) begin
                    $display("FAIL auto_pending_b%0d: got %h want 04", k, d);
                    miscompares++;
                end
            end
        end
        @(posedge clk_usb);
        #1;
        vectors++;
        if (load_o !== 8'h00) begin
            $display("FAIL auto_load_one_cycle: got %h want 00", load_o);
            miscompares++;
        end
        bus_read(A_PEND, 7'd0, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL auto_pending_clear: got %h want 00", d);
            miscompares++;
        end
        bus_read(BASE + 8'd2, 7'd2, d);
        vectors++;
        if (d !== 8'h33) begin
            $display("FAIL auto_readback: got %h want 33", d);
            miscompares++;
        end
    endtask

    task automatic test_commit_all();
        exp_t       e;
        logic [7:0] d;
        logic [7:0] bytes[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bus_write(A_CTRL, 7'd0, 8'h00);
        bus_read(A_CTRL, 7'd0, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL ctrl_off_read: got %h want 00", d);
            miscompares++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                sb.push_back('{$sformatf("staged_r0_b%0d", k), 0, 32'h0, 8'h00});
                bus_write(BASE, 7'(k), bytes[k]);
            end else begin
                sb.push_back('{"staged_r5_b0", 5, 32'h0, 8'h00});
                bus_write(BASE + 8'd5, 7'd0, 8'h7F);
            end
            e = sb.pop_front();
            vectors++;
            if (reg_val(e.ridx) !== e.regv) begin
                $display("FAIL %s_regs: got %h want %h", e.nm, reg_val(e.ridx), e.regv);
                miscompares++;
            end
            vectors++;
            if (load_o !== e.load) begin
                $display("FAIL %s_load: got %h want %h", e.nm, load_o, e.load);
                miscompares++;
            end
        end
        bus_read(BASE, 7'd0, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL staged_read_r0: got %h want 00", d);
            miscompares++;
        end
        bus_read(A_PEND, 7'd0, d);
        vectors++;
        if (d !== 8'h21) begin
            $display("FAIL staged_pending: got %h want 21", d);
            miscompares++;
        end
        sb.push_back('{"commit_all_r0", 0, 32'hDEADBEEF, 8'h21});
        sb.push_back('{"commit_all_r5", 5, 32'h0000007F, 8'h21});
        sb.push_back('{"commit_all_r2", 2, 32'h44332211, 8'h21});
        bus_write(A_CTRL, 7'd0, 8'h01);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (reg_val(e.ridx) !== e.regv) begin
                $display("FAIL %s_regs: got %h want %h", e.nm, reg_val(e.ridx), e.regv);
                miscompares++;
            end
            vectors++;
            if (load_o !== e.load) begin
                $display("FAIL %s_load: got %h want %h", e.nm, load_o, e.load);
                miscompares++;
            end
        end
        @(posedge clk_usb);
        #1;
        vectors++;
        if (load_o !== 8'h00) begin
            $display("FAIL commit_all_one_cycle: got %h want 00", load_o);
            miscompares++;
        end
        bus_read(A_PEND, 7'd0, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL commit_all_pending: got %h want 00", d);
            miscompares++;
        end
        bus_read(BASE, 7'd3, d);
        vectors++;
        if (d !== 8'hDE) begin
            $display("FAIL commit_all_readback: got %h want de", d);
            miscompares++;
        end
        bus_write(A_CTRL, 7'd0, 8'h02);
        bus_read(A_CTRL, 7'd0, d);
        vectors++;
        if (d !== 8'h02) begin
            $display("FAIL ctrl_on_read: got %h want 02", d);
            miscompares++;
        end
    endtask

    task automatic test_sticky();
        logic [7:0] d;
        sticky_set_i = 8'h01;
        @(posedge clk_usb);
        #1;
        sticky_set_i = 8'h00;
        vectors++;
        if (sticky_o !== 8'h01) begin
            $display("FAIL sticky_latency: got %h want 01", sticky_o);
            miscompares++;
        end
        bus_read(A_STATUS, 7'd0, d);
        vectors++;
        if (d !== 8'h01) begin
            $display("FAIL sticky_read: got %h want 01", d);
            miscompares++;
        end
        sticky_set_i = 8'h08;
        bus_write(A_STATUS, 7'd0, 8'h08);
        vectors++;
        if (sticky_o !== 8'h09) begin
            $display("FAIL sticky_set_wins: got %h want 09", sticky_o);
            miscompares++;
        end
        sticky_set_i = 8'h00;
        bus_write(A_STATUS, 7'd0, 8'h08);
        vectors++;
        if (sticky_o !== 8'h01) begin
            $display("FAIL sticky_w1c_bit3: got %h want 01", sticky_o);
            miscompares++;
        end
        bus_write(A_STATUS, 7'd0, 8'hFF);
        vectors++;
        if (sticky_o !== 8'h00) begin
            $display("FAIL sticky_w1c_all: got %h want 00", sticky_o);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{"b2b_first", 4, 32'h01000000, 8'h10});
        sb.push_back('{"b2b_second", 4, 32'h02000000, 8'h10});
        bus_write(BASE + 8'd4, 7'd3, 8'h01);
        e = sb.pop_front();
        vectors++;
        if (reg_val(e.ridx) !== e.regv || load_o !== e.load) begin
            $display("FAIL %s: got regs %h load %h want regs %h load %h",
                     e.nm, reg_val(e.ridx), load_o, e.regv, e.load);
            miscompares++;
        end
        bus_write(BASE + 8'd4, 7'd3, 8'h02);
        e = sb.pop_front();
        vectors++;
        if (reg_val(e.ridx) !== e.regv || load_o !== e.load) begin
            $display("FAIL %s: got regs %h load %h want regs %h load %h",
                     e.nm, reg_val(e.ridx), load_o, e.regv, e.load);
            miscompares++;
        end
        @(posedge clk_usb);
        #1;
        vectors++;
        if (load_o !== 8'h00) begin
            $display("FAIL b2b_load_drop: got %h want 00", load_o);
            miscompares++;
        end
    endtask

    task automatic test_reset_midseq();
        exp_t       e;
        logic [7:0] d;
        bus_write(BASE + 8'd1, 7'd0, 8'hAA);
        bus_write(BASE + 8'd1, 7'd1, 8'hBB);
        bus_read(A_PEND, 7'd0, d);
        vectors++;
        if (d !== 8'h02) begin
            $display("FAIL midseq_pending_before: got %h want 02", d);
            miscompares++;
        end
        @(negedge clk_usb);
        reset_i = 1'b1;
        @(posedge clk_usb);
        #1;
        reset_i = 1'b0;
        vectors++;
        if (regs_o !== '0 || load_o !== 8'h00) begin
            $display("FAIL midseq_reset: got regs %h load %h want 0", regs_o, load_o);
            miscompares++;
        end
        @(posedge clk_usb);
        #1;
        vectors++;
        if (load_o !== 8'h00) begin
            $display("FAIL midseq_reset_exit_load: got %h want 00", load_o);
            miscompares++;
        end
        bus_read(A_PEND, 7'd0, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL midseq_pending_after: got %h want 00", d);
            miscompares++;
        end
        sb.push_back('{"midseq_commit", 1, 32'hCC000000, 8'h02});
        bus_write(BASE + 8'd1, 7'd3, 8'hCC);
        e = sb.pop_front();
        vectors++;
        if (reg_val(e.ridx) !== e.regv || load_o !== e.load) begin
            $display("FAIL %s: got regs %h load %h want regs %h load %h",
                     e.nm, reg_val(e.ridx), load_o, e.regv, e.load);
            miscompares++;
        end
    endtask

    task automatic test_bytecnt_oob();
        exp_t       e;
        logic [7:0] d;
        sb.push_back('{"oob_write", 3, 32'h0, 8'h00});
        bus_write(BASE + 8'd3, 7'd5, 8'h55);
        e = sb.pop_front();
        vectors++;
        if (reg_val(e.ridx) !== e.regv || load_o !== e.load) begin
            $display("FAIL %s: got regs %h load %h want regs %h load %h",
                     e.nm, reg_val(e.ridx), load_o, e.regv, e.load);
            miscompares++;
        end
        bus_read(A_PEND, 7'd0, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL oob_pending: got %h want 00", d);
            miscompares++;
        end
        bus_read(BASE + 8'd3, 7'd5, d);
        vectors++;
        if (d !== 8'h00) begin
            $display("FAIL oob_read: got %h want 00", d);
            miscompares++;
        end
        bus_read(BASE + 8'd1, 7'd3, d);
        vectors++;
        if (d !== 8'hCC) begin
            $display("FAIL oob_neighbour_read: got %h want cc", d);
            miscompares++;
        end
    endtask

    initial begin
        reset_i      = 1'b1;
        reg_address  = 8'h00;
        reg_bytecnt  = 7'd0;
        reg_datai    = 8'h00;
        reg_read     = 1'b0;
        reg_write    = 1'b0;
        sticky_set_i = 8'h00;
        test_reset();
        test_auto_commit();
        test_commit_all();
        test_sticky();
        test_back_to_back();
        test_reset_midseq();
        test_bytecnt_oob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
